// File: rtl/noritsuna_8bitcounter_ai.sv
// Tiny Tapeout tile: 8-bit loadable up/down counter with programmable step, sync clear and wrap flags.
// Define COUNTER_SATURATE_EN to clamp at 8'h00/8'hFF instead of wrapping.
module noritsuna_8bitcounter_ai #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned STEP_W = 4;
    localparam int unsigned EXT_W  = WIDTH + 1;

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              wrap_p_q, wrap_p_d;
    logic              wrap_t_q, wrap_t_d;

    logic              ctl_en, ctl_dir, ctl_load, ctl_sclr;
    logic [STEP_W-1:0] step;
    logic [EXT_W-1:0]  sum_ext;
    logic [EXT_W-1:0]  diff_ext;
    logic              unused_uio_hi;

    assign ctl_en   = ui_in[0];
    assign ctl_dir  = ui_in[1];
    assign ctl_load = ui_in[2];
    assign ctl_sclr = ui_in[3];
    assign unused_uio_hi = ^uio_in[7:4];

    // A zero step would stall the counter, so it is promoted to one.
    assign step     = (uio_in[3:0] == 4'd0) ? 4'd1 : uio_in[3:0];
    assign sum_ext  = {1'b0, cnt_q} + EXT_W'(step);
    assign diff_ext = {1'b0, cnt_q} - EXT_W'(step);

    // Next-state selection in priority order: freeze, clear, load, count, idle.
    always_comb begin
        cnt_d    = cnt_q;
        wrap_p_d = wrap_p_q;
        wrap_t_d = wrap_t_q;
        if (ena) begin
            if (ctl_sclr) begin
                cnt_d    = '0;
                wrap_p_d = 1'b0;
            end else if (ctl_load) begin
                cnt_d    = {ui_in[7:4], uio_in[3:0]};
                wrap_p_d = 1'b0;
            end else if (ctl_en) begin
                if (ctl_dir) begin
                    cnt_d    = sum_ext[WIDTH-1:0];
                    wrap_p_d = sum_ext[WIDTH];
`ifdef COUNTER_SATURATE_EN
                    if (sum_ext[WIDTH]) begin
                        cnt_d = '1;
                    end
`endif
                end else begin
                    cnt_d    = diff_ext[WIDTH-1:0];
                    wrap_p_d = diff_ext[WIDTH];
`ifdef COUNTER_SATURATE_EN
                    if (diff_ext[WIDTH]) begin
                        cnt_d = '0;
                    end
`endif
                end
                if (wrap_p_d) begin
                    wrap_t_d = ~wrap_t_q;
                end
            end else begin
                wrap_p_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            wrap_p_q <= 1'b0;
            wrap_t_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wrap_p_q <= wrap_p_d;
            wrap_t_q <= wrap_t_d;
        end
    end

    // Zero/max flags decode straight from the count register.
    assign uo_out  = cnt_q;
    assign uio_out = {wrap_t_q, wrap_p_q, (cnt_q == '1), (cnt_q == '0), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_noritsuna_8bitcounter_ai.sv
// Self-checking bench for noritsuna_8bitcounter_ai: directed vector table, a wrap-pulse sequence and randomized model checking.
module tb_noritsuna_8bitcounter_ai;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total;
    int bad;

    // Reference model state
    int m_cnt;
    bit m_p;
    bit m_t;

    noritsuna_8bitcounter_ai dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       ena;
        bit [7:0] ui;
        bit [7:0] uio;
        bit [7:0] exp_uo;
        bit [7:0] exp_uio;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Behavioural model: integer arithmetic on the count, range test decides wrap/clamp.
    task automatic model_edge(input bit r, input bit e, input bit [7:0] ui, input bit [7:0] uio);
        int s;
        int n;
        if (r) begin
            m_cnt = 0; m_p = 0; m_t = 0;
        end else if (!e) begin
        end else if (ui[3]) begin
            m_cnt = 0; m_p = 0;
        end else if (ui[2]) begin
            m_cnt = int'({ui[7:4], uio[3:0]}); m_p = 0;
        end else if (ui[0]) begin
            s = (uio[3:0] == 0) ? 1 : int'(uio[3:0]);
            n = ui[1] ? m_cnt + s : m_cnt - s;
            if (n < 0 || n > 255) begin
                m_p = 1;
                m_t = !m_t;
`ifdef COUNTER_SATURATE_EN
                n = (n < 0) ? 0 : 255;
`else
                n = (n + 256) % 256;
`endif
            end else begin
                m_p = 0;
            end
            m_cnt = n;
        end else begin
            m_p = 0;
        end
    endtask

    function automatic int model_uio();
        return (int'(m_t) << 7) | (int'(m_p) << 6) | ((m_cnt == 255) ? 32'h20 : 0) | ((m_cnt == 0) ? 32'h10 : 0);
    endfunction

    task automatic drive_edge(input bit r, input bit e, input bit [7:0] ui, input bit [7:0] uio);
        rst = r; ena = e; ui_in = ui; uio_in = uio;
        @(posedge clk);
        model_edge(r, e, ui, uio);
        #1;
    endtask

    task automatic add(input bit r, input bit e, input bit [7:0] ui, input bit [7:0] uio,
                       input bit [7:0] euo, input bit [7:0] euio);
        vec_t v;
        v.rst = r; v.ena = e; v.ui = ui; v.uio = uio; v.exp_uo = euo; v.exp_uio = euio;
        vecs.push_back(v);
    endtask

    initial begin
        bit [7:0] seq_uo[3];
        bit       seq_p[3];
        total = 0;
        bad   = 0;
        rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        m_cnt = 0; m_p = 0; m_t = 0;

        add(1, 1, 8'hFF, 8'h0F, 8'h00, 8'h10);
        add(1, 0, 8'h5A, 8'hA7, 8'h00, 8'h10);
        add(0, 1, 8'h00, 8'h01, 8'h00, 8'h10);
        add(0, 1, 8'h03, 8'h01, 8'h01, 8'h00);
        add(0, 1, 8'h03, 8'h01, 8'h02, 8'h00);
        add(0, 1, 8'h03, 8'h01, 8'h03, 8'h00);
        add(0, 1, 8'h03, 8'h01, 8'h04, 8'h00);
        add(0, 1, 8'h03, 8'h01, 8'h05, 8'h00);
        add(0, 1, 8'hA4, 8'h05, 8'hA5, 8'h00);
        add(0, 1, 8'hA5, 8'h05, 8'hA5, 8'h00);
        add(0, 1, 8'hF4, 8'h0E, 8'hFE, 8'h00);
`ifdef COUNTER_SATURATE_EN
        add(0, 1, 8'h03, 8'h03, 8'hFF, 8'hE0);
        add(0, 1, 8'h00, 8'h03, 8'hFF, 8'hA0);
        add(0, 1, 8'h04, 8'h02, 8'h02, 8'h80);
        add(0, 1, 8'h01, 8'h04, 8'h00, 8'h50);
        add(0, 1, 8'h01, 8'h00, 8'h00, 8'hD0);
        add(0, 1, 8'h54, 8'h05, 8'h55, 8'h80);
        add(0, 1, 8'h0F, 8'h05, 8'h00, 8'h90);
        add(0, 1, 8'h03, 8'h02, 8'h02, 8'h80);
        add(0, 0, 8'h03, 8'h02, 8'h02, 8'h80);
        add(0, 0, 8'h03, 8'h02, 8'h02, 8'h80);
        add(0, 0, 8'h03, 8'h02, 8'h02, 8'h80);
        add(0, 1, 8'h03, 8'h02, 8'h04, 8'h80);
        add(0, 1, 8'hF4, 8'h0F, 8'hFF, 8'hA0);
`else
        add(0, 1, 8'h03, 8'h03, 8'h01, 8'hC0);
        add(0, 1, 8'h00, 8'h03, 8'h01, 8'h80);
        add(0, 1, 8'h04, 8'h02, 8'h02, 8'h80);
        add(0, 1, 8'h01, 8'h04, 8'hFE, 8'h40);
        add(0, 1, 8'h01, 8'h00, 8'hFD, 8'h00);
        add(0, 1, 8'h54, 8'h05, 8'h55, 8'h00);
        add(0, 1, 8'h0F, 8'h05, 8'h00, 8'h10);
        add(0, 1, 8'h03, 8'h02, 8'h02, 8'h00);
        add(0, 0, 8'h03, 8'h02, 8'h02, 8'h00);
        add(0, 0, 8'h03, 8'h02, 8'h02, 8'h00);
        add(0, 0, 8'h03, 8'h02, 8'h02, 8'h00);
        add(0, 1, 8'h03, 8'h02, 8'h04, 8'h00);
        add(0, 1, 8'hF4, 8'h0F, 8'hFF, 8'h20);
`endif
        add(1, 0, 8'h0F, 8'h0F, 8'h00, 8'h10);

        foreach (vecs[i]) begin
            drive_edge(vecs[i].rst, vecs[i].ena, vecs[i].ui, vecs[i].uio);
            check($sformatf("vec%0d uo_out", i), int'(uo_out), int'(vecs[i].exp_uo));
            check($sformatf("vec%0d uio_out", i), int'(uio_out), int'(vecs[i].exp_uio));
            check($sformatf("vec%0d uio_oe", i), int'(uio_oe), 32'hF0);
        end

        // Wrap pulse lasts one edge while counting continues past the boundary.
        drive_edge(0, 1, 8'hF4, 8'h00);
`ifdef COUNTER_SATURATE_EN
        seq_uo = '{8'hFF, 8'hFF, 8'hFF};
        seq_p  = '{1'b0, 1'b1, 1'b1};
`else
        seq_uo = '{8'hFF, 8'h0E, 8'h1D};
        seq_p  = '{1'b0, 1'b1, 1'b0};
`endif
        for (int k = 0; k < 3; k++) begin
            drive_edge(0, 1, 8'h03, 8'h0F);
            check($sformatf("seq%0d uo_out", k), int'(uo_out), int'(seq_uo[k]));
            check($sformatf("seq%0d wrap_p", k), int'(uio_out[6]), int'(seq_p[k]));
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            bit       r;
            bit       e;
            bit [7:0] ui;
            bit [7:0] uio;
            r   = ($urandom_range(0, 39) == 0);
            e   = ($urandom_range(0, 7) != 0);
            ui  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ui[3:2] = 2'b00;
            uio = 8'($urandom);
            drive_edge(r, e, ui, uio);
            check($sformatf("rnd%0d uo_out", k), int'(uo_out), m_cnt);
            check($sformatf("rnd%0d uio_out", k), int'(uio_out), model_uio());
            check($sformatf("rnd%0d uio_oe", k), int'(uio_oe), 32'hF0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noritsuna_8bitcounter_ai.md
Name: noritsuna_8bitcounter_ai

Overview:
- 8-bit loadable up/down counter with programmable step, sync clear and status flags.
- Packaged as a Tiny Tapeout user tile; uses the standard ui_in/uo_out/uio_* pin set.
- The count drives uo_out directly.
- Flags go out on the upper uio nibble; step and load-low data come in on the lower uio nibble.

Parameters:
- WIDTH, 8, counter width; fixed at 8 for the tile pinout, and other values are unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset; the tile wrapper drives it from the inverted pad rst_n.
- ena  input  1  tile enable; while low, every state update except reset is frozen.
- ui_in  input  8  [0] en, [1] dir (1=up, 0=down), [2] load, [3] sclr, [7:4] load value high nibble.
- uo_out  output  8  current count register.
- uio_in  input  8  [3:0] step size and load value low nibble; [7:4] ignored.
- uio_out  output  8  [3:0]=0, [4] zero, [5] max, [6] wrap pulse, [7] wrap toggle.
- uio_oe  output  8  constant 8'hF0.

Behaviour:
- One clock domain. All state updates on rising clk.
- Registered state: cnt[7:0], wrap_p, wrap_t.
- Update priority per edge:
  - rst=1: cnt=0, wrap_p=0, wrap_t=0.
  - Else ena=0: hold all state.
  - Else sclr=1: cnt=0, wrap_p=0; wrap_t holds.
  - Else load=1: cnt={ui_in[7:4], uio_in[3:0]}, wrap_p=0.
  - Else en=1: count by step (below).
  - Else hold cnt, wrap_p=0.
- Step: s = uio_in[3:0]; s==0 is treated as 1. Range 1..15.
- Up: next = cnt + s mod 256; carry out of bit 7 means wrap.
- Down: next = cnt - s mod 256; borrow means wrap.
- On a wrap edge: wrap_p=1 for exactly that one cycle and wrap_t inverts. Non-wrapping count: wrap_p=0.
- Outputs:
  - uo_out = cnt, one-edge latency from any control input.
  - uio_out[4] = (cnt==0), derived combinationally from the register.
  - uio_out[5] = (cnt==255).
  - uio_out[6] = wrap_p; uio_out[7] = wrap_t.
  - uio_out[3:0] = 0 always; uio_oe = 8'hF0 always, including during reset.
- Reset values: uo_out=8'h00, uio_out=8'h10.
- Reset asserted mid-count takes effect on the next edge regardless of ena/sclr/load/en.
- Simultaneous sclr+load+en: sclr wins. load+en: load wins and no count occurs that cycle.
- dir is sampled each counting cycle; it may change every cycle.
- No X propagation: every register is reset.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined:
  - Up counting clamps at 8'hFF; down counting clamps at 8'h00.
  - A clamp event (the result would have wrapped) sets wrap_p for one cycle and toggles wrap_t.
  - Counting further while already at the limit is also a clamp event.
- Undefined: modular wrap as described above.
- All other behaviour is identical in both builds.

Test Plan:
- rst=1 for 2 cycles with random inputs -> uo_out=8'h00, uio_out=8'h10, uio_oe=8'hF0; release -> state held while en=0.
- ena=1, ui_in=8'h03 (en, up), uio_in=8'h01, 5 edges -> uo_out 1,2,3,4,5; uio_out[4]=0 after the first edge.
- ui_in=8'hA4 (load, hi=A), uio_in=8'h05 -> uo_out=8'hA5 next edge. Repeat with ui_in=8'hA5 (load+en) -> still 8'hA5, no count.
- Load 8'hFE, then ui_in=8'h03, uio_in=8'h03 -> uo_out=8'h01, uio_out[6]=1 for one cycle, uio_out[7] toggles 0->1. With COUNTER_SATURATE_EN -> uo_out=8'hFF, uio_out[5]=1, same flag pulse.
- Load 8'h02, then ui_in=8'h01 (down), uio_in=8'h04 -> uo_out=8'hFE with wrap pulse. Then uio_in=8'h00 -> 8'hFD (step 0 acts as 1).
- ui_in=8'h0F (sclr+load+en+up) from 8'h55 -> uo_out=8'h00. ena=0 with en=1 for 3 edges -> count unchanged. rst mid-count -> 8'h00 next edge.
